pipeline_hazard_unit: RTL and testbench

- Parametrised hazard detection and forwarding controller for the in-order loopyV pipeline. Generalises the fixed IF/DE/EX/MEM/WB pipe to DEPTH tracked post-decode stages.
- Tracks each in-flight instruction's destination register in a shift-register scoreboard. Generates per-operand forwarding selects, load-use stall/bubble insertion and flush handling.
- Sits beside the decoder; its outputs steer the IDEX pipe register and the operand multiplexers.

---
 rtl/pipeline_hazard_unit.sv | 120 ++++++++++++
 tb/tb_pipeline_hazard_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_hazard_unit.sv
// Hazard detection and operand-forwarding controller for the in-order loopyV pipeline.
// A shift-register scoreboard tracks DEPTH post-decode stages; stage 1 is EX and stage DEPTH is WB.
module pipeline_hazard_unit #(
  parameter int DEPTH            = 3,
  parameter int LOAD_READY_STAGE = 2,
  parameter int REG_ADDR_W       = 5,
  parameter int CNT_W            = 16,
  localparam int SEL_W           = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  deValid,
  input  logic [REG_ADDR_W-1:0] deRs1Addr,
  input  logic                  deRs1Used,
  input  logic [REG_ADDR_W-1:0] deRs2Addr,
  input  logic                  deRs2Used,
  input  logic [REG_ADDR_W-1:0] deRdAddr,
  input  logic                  deRdWriteEn,
  input  logic                  deIsLoad,
  input  logic                  flush,
  output logic                  stall,
  output logic [SEL_W-1:0]      fwdSelA,
  output logic [SEL_W-1:0]      fwdSelB,
  output logic [DEPTH-1:0]      stageValid,
  output logic [CNT_W-1:0]      stallCount
);

  typedef struct packed {
    logic             haz;
    logic [SEL_W-1:0] sel;
  } lookup_t;

  // Bit/element i of each vector describes stage i+1.
  logic [DEPTH-1:0]                 r_valid;
  logic [DEPTH-1:0]                 r_we;
  logic [DEPTH-1:0]                 r_load;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] r_rd;
  logic [CNT_W-1:0]                 r_stall_cnt;

  lookup_t w_look_a;
  lookup_t w_look_b;
  logic    w_stall;
  logic    w_accept;

  // Nearest matching producer wins; a load that has not yet reached its ready stage hazards the operand.
  function automatic lookup_t operand_lookup(
    input logic [REG_ADDR_W-1:0]            rs,
    input logic                             used,
    input logic                             de_valid,
    input logic [DEPTH-1:0]                 valid,
    input logic [DEPTH-1:0]                 we,
    input logic [DEPTH-1:0]                 load,
    input logic [DEPTH-1:0][REG_ADDR_W-1:0] rd
  );
    lookup_t res;
    logic    found;
    res   = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && de_valid && used && (rs != '0) && valid[i] && we[i] && (rd[i] == rs)) begin
        found = 1'b1;
        if (load[i] && ((i + 1) < LOAD_READY_STAGE)) begin
          res.haz = 1'b1;
          res.sel = '0;
        end else begin
          res.haz = 1'b0;
          res.sel = SEL_W'(i + 1);
        end
      end else begin
        found = found;
      end
    end
    return res;
  endfunction

  // Forwarding selects and stall are combinational from the scoreboard and decode inputs.
  always_comb begin
    w_look_a = operand_lookup(deRs1Addr, deRs1Used, deValid, r_valid, r_we, r_load, r_rd);
    w_look_b = operand_lookup(deRs2Addr, deRs2Used, deValid, r_valid, r_we, r_load, r_rd);
    if (flush) begin
      w_stall = 1'b0;
    end else begin
      w_stall = w_look_a.haz | w_look_b.haz;
    end
    w_accept = deValid & ~w_stall & ~flush;
  end

  // Scoreboard shift: no enable, a stalled or flushed decode slot enters EX as an all-zero bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
      r_we    <= '0;
      r_load  <= '0;
      r_rd    <= '0;
    end else begin
      r_valid <= {r_valid[DEPTH-2:0], w_accept};
      r_we    <= {r_we[DEPTH-2:0], w_accept & deRdWriteEn};
      r_load  <= {r_load[DEPTH-2:0], w_accept & deIsLoad};
      r_rd    <= {r_rd[DEPTH-2:0], (w_accept ? deRdAddr : {REG_ADDR_W{1'b0}})};
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end else begin
      r_stall_cnt <= r_stall_cnt;
    end
  end

  assign stall      = w_stall;
  assign fwdSelA    = w_look_a.sel;
  assign fwdSelB    = w_look_b.sel;
  assign stageValid = r_valid;
  assign stallCount = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench: default, deep (DEPTH=5, LOAD_READY_STAGE=4) and narrow-counter (CNT_W=2)
// instances share stimulus; each has its own instruction-level reference model.
module tb_pipeline_hazard_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       de_valid, de_rs1_used, de_rs2_used, de_we, de_ld, de_flush;
  logic [4:0] de_rs1, de_rs2, de_rd;

  logic       st0, st1, st2;
  logic [1:0] sa0, sb0, sa2, sb2;
  logic [2:0] sa1, sb1;
  logic [2:0] sv0, sv2;
  logic [4:0] sv1;
  logic [15:0] cnt0, cnt1;
  logic [1:0] cnt2;

  int chk = 0;
  int err = 0;

  pipeline_hazard_unit u0 (
    .clk(clk), .rst(rst), .deValid(de_valid), .deRs1Addr(de_rs1), .deRs1Used(de_rs1_used),
    .deRs2Addr(de_rs2), .deRs2Used(de_rs2_used), .deRdAddr(de_rd), .deRdWriteEn(de_we),
    .deIsLoad(de_ld), .flush(de_flush), .stall(st0), .fwdSelA(sa0), .fwdSelB(sb0),
    .stageValid(sv0), .stallCount(cnt0));

  pipeline_hazard_unit #(.DEPTH(5), .LOAD_READY_STAGE(4)) u1 (
    .clk(clk), .rst(rst), .deValid(de_valid), .deRs1Addr(de_rs1), .deRs1Used(de_rs1_used),
    .deRs2Addr(de_rs2), .deRs2Used(de_rs2_used), .deRdAddr(de_rd), .deRdWriteEn(de_we),
    .deIsLoad(de_ld), .flush(de_flush), .stall(st1), .fwdSelA(sa1), .fwdSelB(sb1),
    .stageValid(sv1), .stallCount(cnt1));

  pipeline_hazard_unit #(.CNT_W(2)) u2 (
    .clk(clk), .rst(rst), .deValid(de_valid), .deRs1Addr(de_rs1), .deRs1Used(de_rs1_used),
    .deRs2Addr(de_rs2), .deRs2Used(de_rs2_used), .deRdAddr(de_rd), .deRdWriteEn(de_we),
    .deIsLoad(de_ld), .flush(de_flush), .stall(st2), .fwdSelA(sa2), .fwdSelB(sb2),
    .stageValid(sv2), .stallCount(cnt2));

  logic [31:0] obs_st[3], obs_sa[3], obs_sb[3], obs_sv[3], obs_cnt[3];
  always_comb begin
    obs_st[0] = 32'(st0);  obs_st[1] = 32'(st1);  obs_st[2] = 32'(st2);
    obs_sa[0] = 32'(sa0);  obs_sa[1] = 32'(sa1);  obs_sa[2] = 32'(sa2);
    obs_sb[0] = 32'(sb0);  obs_sb[1] = 32'(sb1);  obs_sb[2] = 32'(sb2);
    obs_sv[0] = 32'(sv0);  obs_sv[1] = 32'(sv1);  obs_sv[2] = 32'(sv2);
    obs_cnt[0] = 32'(cnt0); obs_cnt[1] = 32'(cnt1); obs_cnt[2] = 32'(cnt2);
  end

  // Reference model: in-flight instructions per stage (index 1..depth) for each instance.
  int       m_depth[3] = '{3, 5, 3};
  int       m_lrs[3]   = '{2, 4, 2};
  int       m_max[3]   = '{65535, 65535, 3};
  bit       mv[3][9];
  bit [4:0] mrd[3][9];
  bit       mwe[3][9];
  bit       mld[3][9];
  int       mcnt[3];

  task automatic op_look(input int n, input bit [4:0] rs, input bit used, output int sel, output bit haz);
    bit found;
    sel = 0; haz = 1'b0; found = 1'b0;
    if (de_valid && used && rs != 5'd0) begin
      for (int k = 1; k <= m_depth[n]; k++) begin
        if (!found && mv[n][k] && mwe[n][k] && mrd[n][k] == rs) begin
          found = 1'b1;
          if (mld[n][k] && k < m_lrs[n]) haz = 1'b1;
          else sel = k;
        end
      end
    end
  endtask

  task automatic model_eval(input int n, output bit stl, output int sa, output int sb);
    bit ha, hb;
    op_look(n, de_rs1, de_rs1_used, sa, ha);
    op_look(n, de_rs2, de_rs2_used, sb, hb);
    stl = (ha || hb) && !de_flush;
  endtask

  function automatic int model_sv(input int n);
    int v;
    v = 0;
    for (int k = 1; k <= m_depth[n]; k++) if (mv[n][k]) v = v | (1 << (k - 1));
    return v;
  endfunction

  // Advance one clock edge for DUTs and models, then settle 1 time unit past the edge.
  task automatic step();
    bit stl[3];
    int sa, sb;
    for (int n = 0; n < 3; n++) model_eval(n, stl[n], sa, sb);
    @(posedge clk);
    for (int n = 0; n < 3; n++) begin
      if (rst) begin
        for (int k = 0; k < 9; k++) begin
          mv[n][k] = 1'b0; mrd[n][k] = 5'd0; mwe[n][k] = 1'b0; mld[n][k] = 1'b0;
        end
        mcnt[n] = 0;
      end else begin
        for (int k = m_depth[n]; k >= 2; k--) begin
          mv[n][k] = mv[n][k-1]; mrd[n][k] = mrd[n][k-1];
          mwe[n][k] = mwe[n][k-1]; mld[n][k] = mld[n][k-1];
        end
        mv[n][1]  = de_valid && !stl[n] && !de_flush;
        mrd[n][1] = mv[n][1] ? de_rd : 5'd0;
        mwe[n][1] = mv[n][1] && de_we;
        mld[n][1] = mv[n][1] && de_ld;
        if (stl[n] && mcnt[n] < m_max[n]) mcnt[n]++;
      end
    end
    #1;
  endtask

  task automatic set_de(input bit v, input bit [4:0] r1, input bit u1, input bit [4:0] r2,
                        input bit u2, input bit [4:0] rd, input bit we, input bit ld);
    de_valid = v; de_rs1 = r1; de_rs1_used = u1; de_rs2 = r2; de_rs2_used = u2;
    de_rd = rd; de_we = we; de_ld = ld;
  endtask

  task automatic test_reset();
    rst = 1'b1; de_flush = 1'b0;
    set_de(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0);
    step(); step();
    chk++; if (sv0 !== 3'b000) begin err++; $display("FAIL reset_stageValid: got %b expected 000", sv0); end
    chk++; if (st0 !== 1'b0) begin err++; $display("FAIL reset_stall: got %b expected 0", st0); end
    chk++; if (sa0 !== 2'd0 || sb0 !== 2'd0) begin err++; $display("FAIL reset_fwd: got %0d/%0d expected 0/0", sa0, sb0); end
    chk++; if (cnt0 !== 16'd0) begin err++; $display("FAIL reset_count: got %0d expected 0", cnt0); end
    chk++; if (sv1 !== 5'b00000) begin err++; $display("FAIL reset_stageValid_d5: got %b expected 00000", sv1); end
    rst = 1'b0;
    set_de(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    step();
  endtask

  task automatic test_alu_chain();
    set_de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0); step();
    set_de(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    chk++; if (sa0 !== 2'd1 || sb0 !== 2'd1) begin err++; $display("FAIL alu_fwd_ex: got %0d/%0d expected 1/1", sa0, sb0); end
    chk++; if (st0 !== 1'b0) begin err++; $display("FAIL alu_stall: got %b expected 0", st0); end
    step();
    set_de(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); step();
    set_de(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    chk++; if (sa0 !== 2'd3 || sb0 !== 2'd3) begin err++; $display("FAIL alu_fwd_wb: got %0d/%0d expected 3/3", sa0, sb0); end
    step();
    set_de(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); step();
  endtask

  task automatic test_load_use();
    set_de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); step();
    set_de(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd2, 1'b1, 1'b0); #1;
    chk++; if (st0 !== 1'b1 || sb0 !== 2'd0) begin err++; $display("FAIL loaduse_stall: got stall=%b sel=%0d expected 1/0", st0, sb0); end
    step(); #1;
    chk++; if (sv0 !== 3'b010) begin err++; $display("FAIL loaduse_bubble: got %b expected 010", sv0); end
    chk++; if (st0 !== 1'b0 || sb0 !== 2'd2) begin err++; $display("FAIL loaduse_fwd: got stall=%b sel=%0d expected 0/2", st0, sb0); end
    chk++; if (cnt0 !== 16'd1) begin err++; $display("FAIL loaduse_count: got %0d expected 1", cnt0); end
    step();
    set_de(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); step();
  endtask

  task automatic test_priority_x0();
    set_de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); step();
    set_de(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); step();
    set_de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0); step();
    set_de(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); #1;
    chk++; if (sa0 !== 2'd1 || st0 !== 1'b0) begin err++; $display("FAIL youngest_wins: got sel=%0d stall=%b expected 1/0", sa0, st0); end
    step();
    set_de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0); step();
    set_de(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    chk++; if (sa0 !== 2'd0 || sb0 !== 2'd0 || st0 !== 1'b0) begin err++; $display("FAIL x0_alu: got %0d/%0d stall=%b expected 0/0/0", sa0, sb0, st0); end
    step();
    set_de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1); step();
    set_de(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0); #1;
    chk++; if (st0 !== 1'b0) begin err++; $display("FAIL x0_load: got stall=%b expected 0", st0); end
    step();
    set_de(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); step();
  endtask

  task automatic test_flush();
    set_de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1); step();
    set_de(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd4, 1'b1, 1'b0); de_flush = 1'b1; #1;
    chk++; if (st0 !== 1'b0) begin err++; $display("FAIL flush_stall: got %b expected 0", st0); end
    step();
    chk++; if (sv0 !== 3'b010) begin err++; $display("FAIL flush_bubble: got %b expected 010", sv0); end
    chk++; if (cnt0 !== 16'd1) begin err++; $display("FAIL flush_count: got %0d expected 1", cnt0); end
    de_flush = 1'b0;
    set_de(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); step();
  endtask

  task automatic test_param_sweep();
    for (int i = 0; i < 5; i++) step();
    set_de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1); step();
    set_de(1'b1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk++; if (st1 !== 1'b1 || sa1 !== 3'd0) begin err++; $display("FAIL d5_stall_%0d: got stall=%b sel=%0d expected 1/0", i, st1, sa1); end
      step();
    end
    #1;
    chk++; if (st1 !== 1'b0 || sa1 !== 3'd4) begin err++; $display("FAIL d5_fwd: got stall=%b sel=%0d expected 0/4", st1, sa1); end
    step();
    set_de(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step();
  endtask

  task automatic test_saturation();
    for (int r = 0; r < 5; r++) begin
      set_de(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd10, 1'b1, 1'b1); step();
      set_de(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); step(); step();
    end
    set_de(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0); step();
    chk++; if (cnt2 !== 2'd3) begin err++; $display("FAIL sat_count: got %0d expected 3", cnt2); end
    chk++; if (obs_cnt[0] !== mcnt[0]) begin err++; $display("FAIL wide_count: got %0d expected %0d", cnt0, mcnt[0]); end
  endtask

  task automatic test_random();
    bit es;
    int ea, eb;
    for (int c = 0; c < 400; c++) begin
      rst      = ($urandom_range(0, 49) == 0);
      de_flush = ($urandom_range(0, 9) == 0);
      set_de($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
             1'($urandom_range(0, 1)), $urandom_range(0, 9) < 3);
      #1;
      for (int n = 0; n < 3; n++) begin
        model_eval(n, es, ea, eb);
        chk++; if (obs_st[n] !== 32'(es)) begin err++; $display("FAIL rnd_stall u%0d cyc %0d: got %0d expected %0d", n, c, obs_st[n], es); end
        chk++; if (obs_sa[n] !== ea) begin err++; $display("FAIL rnd_selA u%0d cyc %0d: got %0d expected %0d", n, c, obs_sa[n], ea); end
        chk++; if (obs_sb[n] !== eb) begin err++; $display("FAIL rnd_selB u%0d cyc %0d: got %0d expected %0d", n, c, obs_sb[n], eb); end
        chk++; if (obs_sv[n] !== model_sv(n)) begin err++; $display("FAIL rnd_stageValid u%0d cyc %0d: got %0h expected %0h", n, c, obs_sv[n], model_sv(n)); end
        chk++; if (obs_cnt[n] !== mcnt[n]) begin err++; $display("FAIL rnd_count u%0d cyc %0d: got %0d expected %0d", n, c, obs_cnt[n], mcnt[n]); end
      end
      step();
    end
    rst = 1'b0; de_flush = 1'b0;
  endtask

  initial begin
    #1;
    test_reset();
    test_alu_chain();
    test_load_use();
    test_priority_x0();
    test_flush();
    test_param_sweep();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", chk, err);
    $finish;
  end

endmodule
